// File: rtl/frontend_pkg.sv
// frontend_pkg: shared definitions for the detector frontend.
//   WORD_W   - width of words on the merged output stream
//   PERIOD_W - width of the timer period count
//   TAG_HDR  - top nibble marking a time-tag word (events never use it)
//   state_e  - timer-realignment sequencer states
//   make_tag - builds a time-tag word from a period count
package frontend_pkg;

  localparam int WORD_W   = 64;
  localparam int PERIOD_W = 48;

  localparam logic [3:0] TAG_HDR = 4'hF;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    SYNC = 2'd1,
    BLNK = 2'd2
  } state_e;

  function automatic logic [WORD_W-1:0] make_tag(input logic [PERIOD_W-1:0] p);
    return {TAG_HDR, 12'h000, p};
  endfunction

endpackage

// File: rtl/tt_outreg.sv
// tt_outreg: single-stage output register merging two sources with
// valid/ready backpressure. The tag source has strict priority over events.
//   clk, rst             - clock, synchronous active-high reset
//   tag_valid, tag_data  - pending tag word (held by the parent)
//   tag_take             - pulses when the tag is loaded into the output
//   ev_valid, ev_data    - event stream input
//   ev_ready             - event accepted when ev_valid && ev_ready
//   out_valid, out_data  - merged output word
//   out_ready            - downstream ready
module tt_outreg
  import frontend_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              tag_valid,
  input  logic [WORD_W-1:0] tag_data,
  output logic              tag_take,
  input  logic              ev_valid,
  input  logic [WORD_W-1:0] ev_data,
  output logic              ev_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  logic              out_valid_q, out_valid_d;
  logic [WORD_W-1:0] out_data_q, out_data_d;
  logic              load;

  // The register may take a new word whenever it is empty or draining.
  assign load     = !out_valid_q || out_ready;
  assign tag_take = load && tag_valid;
  // A pending tag blocks events for the cycle in which it is loaded.
  assign ev_ready = load && !tag_valid;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load) begin
      if (tag_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = tag_data;
      end else if (ev_valid) begin
        out_valid_d = 1'b1;
        out_data_d  = ev_data;
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: rtl/tt_scheduler.sv
// tt_scheduler: controller for the frontend timer.
// Sequences timer realignment (drives timer reset on sync_req, then blanks
// period_done for BLANK cycles), turns every TT_DIV-th accepted period_done
// into a 64-bit time-tag, and merges tags ahead of detector events on one
// valid/ready output stream.
//   clk, rst              - clock, synchronous active-high reset
//   en                    - tag generation enable (events always pass)
//   sync_req              - one-cycle realignment request
//   timer_rst             - reset to the timer
//   syncing               - high while the sequencer is not in RUN
//   period_done, period   - timer rollover pulse and its period count
//   ev_data/valid/ready   - event input stream
//   out_data/valid/ready  - merged output stream
//   tt_overflow           - sticky: a tag was dropped (cleared by rst only)
module tt_scheduler
  import frontend_pkg::*;
#(
  parameter int TT_DIV = 1,
  parameter int BLANK  = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                sync_req,
  output logic                timer_rst,
  output logic                syncing,
  input  logic                period_done,
  input  logic [PERIOD_W-1:0] period,
  input  logic [WORD_W-1:0]   ev_data,
  input  logic                ev_valid,
  output logic                ev_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                tt_overflow
);

  localparam logic [7:0] DIV_LAST   = 8'(TT_DIV - 1);
  localparam logic [3:0] BLANK_LAST = 4'(BLANK - 1);

  state_e            state_q, state_d;
  logic [3:0]        blank_cnt_q, blank_cnt_d;
  logic [7:0]        div_cnt_q, div_cnt_d;
  logic [WORD_W-1:0] tag_data_q, tag_data_d;
  logic              tag_pend_q, tag_pend_d;
  logic              tt_overflow_q, tt_overflow_d;
  logic              syncing_q, syncing_d;
  logic              sync_pulse_q, sync_pulse_d;

  logic accepted;
  logic tag_due;
  logic tag_take;

  assign accepted = period_done && en && (state_q == RUN);
  assign tag_due  = accepted && (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d       = state_q;
    blank_cnt_d   = blank_cnt_q;
    div_cnt_d     = div_cnt_q;
    tag_data_d    = tag_data_q;
    tag_pend_d    = tag_pend_q;
    tt_overflow_d = tt_overflow_q;

    // Realignment sequencer; sync_req is only honoured in RUN.
    case (state_q)
      RUN: begin
        if (sync_req) state_d = SYNC;
      end
      SYNC: begin
        state_d     = BLNK;
        blank_cnt_d = 4'd0;
      end
      BLNK: begin
        if (blank_cnt_q == BLANK_LAST) state_d = RUN;
        else                           blank_cnt_d = blank_cnt_q + 4'd1;
      end
      default: state_d = RUN;
    endcase

    // A pulse accepted in the same cycle as sync_req still counts; the
    // divider is cleared one cycle later while in SYNC.
    if (state_q == SYNC) begin
      div_cnt_d = 8'd0;
    end else if (accepted) begin
      div_cnt_d = tag_due ? 8'd0 : div_cnt_q + 8'd1;
    end

    if (tag_take) tag_pend_d = 1'b0;

    // The slot is free if empty or being drained this very cycle;
    // otherwise the older tag wins and the new one is dropped.
    if (tag_due) begin
      if (!tag_pend_q || tag_take) begin
        tag_data_d = make_tag(period);
        tag_pend_d = 1'b1;
      end else begin
        tt_overflow_d = 1'b1;
      end
    end

    syncing_d    = (state_d != RUN);
    sync_pulse_d = (state_d == SYNC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= RUN;
      blank_cnt_q   <= 4'd0;
      div_cnt_q     <= 8'd0;
      tag_data_q    <= '0;
      tag_pend_q    <= 1'b0;
      tt_overflow_q <= 1'b0;
      syncing_q     <= 1'b0;
      sync_pulse_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      blank_cnt_q   <= blank_cnt_d;
      div_cnt_q     <= div_cnt_d;
      tag_data_q    <= tag_data_d;
      tag_pend_q    <= tag_pend_d;
      tt_overflow_q <= tt_overflow_d;
      syncing_q     <= syncing_d;
      sync_pulse_q  <= sync_pulse_d;
    end
  end

  // rst passes straight through so the timer is held in reset with us.
  assign timer_rst   = rst | sync_pulse_q;
  assign syncing     = syncing_q;
  assign tt_overflow = tt_overflow_q;

  tt_outreg u_outreg (
    .clk       (clk),
    .rst       (rst),
    .tag_valid (tag_pend_q),
    .tag_data  (tag_data_q),
    .tag_take  (tag_take),
    .ev_valid  (ev_valid),
    .ev_data   (ev_data),
    .ev_ready  (ev_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

endmodule
